core_run_ctrl: RTL
==================

// Module: core_run_ctrl
// PURPOSE
//  Run sequencer for the 3-stage pipelined RISC-V core (top). Accepts a job (8-bit operand + start),
//  holds the core in PC reset, drives the operand, releases the core, waits for halt or timeout,
//  then captures the 10-bit core output and reports it through a valid/ack handshake.
//  Replaces hand-driven pc_rst/in1 sequencing; sits between host/board logic and top.
// PARAMETERS
//  IN_W        8    operand width (core in1)
//  OUT_W       10   result width (core out1)
//  RST_CYCLES  5    cycles core_pc_rst held high per job (>=1)
//  TIMEOUT     800  max RUN cycles before forced capture (>=2)
//  CNT_W       16   cycle_count width (2**CNT_W > TIMEOUT)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      asynchronous, active-low reset
//  start         in   1      job request pulse/level, sampled in IDLE/DONE
//  abort         in   1      cancel running job
//  in_data       in   IN_W   job operand, latched on accepted start
//  result_ack    in   1      consumer accepts result
//  core_halt     in   1      core finished (level), sampled in RUN only
//  core_out      in   OUT_W  core result bus (out1)
//  core_pc_rst   out  1      to core pc_rst, active-high
//  core_in       out  IN_W   to core in1, stable for whole job
//  result        out  OUT_W  captured core_out
//  result_valid  out  1      result available
//  timed_out     out  1      result captured by timeout, not halt
//  busy          out  1      state is RESET or RUN
//  cycle_count   out  CNT_W  RUN cycles of current/last job
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, core_pc_rst=1, core_in=0, result=0, result_valid=0,
//   timed_out=0, busy=0, cycle_count=0. All outputs registered.
//  States: IDLE, RESET, RUN, DONE.
//  IDLE: core_pc_rst=1. start=1 & abort=0 -> latch in_data to core_in, clear cycle_count,
//   result_valid, timed_out; go RESET. start&abort in same cycle -> stay IDLE.
//  RESET: core_pc_rst=1, busy=1; internal counter runs RST_CYCLES cycles, then RUN;
//   core_pc_rst falls on the same edge that enters RUN. core_halt ignored.
//  RUN: core_pc_rst=0, busy=1; cycle_count +1 every RUN cycle (halt cycle included).
//   core_halt=1 -> result<=core_out, timed_out<=0, result_valid<=1, core_pc_rst<=1, go DONE.
//   No halt and cycle_count==TIMEOUT-1 -> same capture with timed_out<=1, cycle_count=TIMEOUT.
//   Halt on the timeout cycle: halt wins, timed_out=0.
//  abort=1 in RESET or RUN: go IDLE next edge, core_pc_rst<=1, result_valid stays 0,
//   cycle_count frozen. abort has priority over halt/timeout in same cycle.
//  DONE: core_pc_rst=1, result/timed_out/cycle_count held, result_valid=1.
//   result_ack=1 -> result_valid<=0, go IDLE. start=1 (with or without ack) -> treated as
//   ack plus new job: latch in_data, go RESET directly. abort ignored in DONE/IDLE.
//  start while busy ignored; in_data changes mid-job do not affect core_in.
//  cycle_count saturates never (bounded by TIMEOUT).
// STRUCTURE
//  Shared header run_ctrl_defs.vh: state encodings (ST_IDLE=2'd0, ST_RESET=2'd1,
//   ST_RUN=2'd2, ST_DONE=2'd3) and default widths, reused by bench and board top.
//  One sub-module: ctrl_cycle_counter (CNT_W, sync clear, enable, terminal-count compare),
//   instanced once for the RESET dwell and once for cycle_count. FSM in core_run_ctrl.
// TESTING
//  1 rst low mid-RUN -> all outputs at reset values immediately, core_pc_rst=1, state IDLE.
//  2 in_data=8'h08, start 1 cycle, halt after 37 RUN cycles, core_out=10'h02A -> core_pc_rst
//    high exactly 5 cycles, result=10'h02A, result_valid=1, timed_out=0, cycle_count=37.
//  3 core_halt never asserted, TIMEOUT=800 -> DONE after 800 RUN cycles, timed_out=1,
//    cycle_count=800, result=core_out sampled on that edge.
//  4 halt asserted on RUN cycle 800 exactly -> timed_out=0, cycle_count=800.
//  5 abort in RESET and again at RUN cycle 10 -> back to IDLE, result_valid=0,
//    core_pc_rst=1; start during RUN ignored.
//  6 DONE, start with in_data=8'd15 and no ack -> result_valid drops, core_in=8'd15,
//    new RESET dwell of 5 cycles; ack alone returns to IDLE.

Source files
------------

// File: rtl/core_run_ctrl_pkg.sv
// Shared definitions for the core run sequencer: state encodings, default widths
// and a small state-decode helper.
package core_run_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RESET = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEF_IN_W       = 8;
  localparam int DEF_OUT_W      = 10;
  localparam int DEF_RST_CYCLES = 5;
  localparam int DEF_TIMEOUT    = 800;
  localparam int DEF_CNT_W      = 16;

  function automatic logic st_busy(input logic [1:0] st);
    return (st == ST_RESET) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/core_run_ctrl_cycle_counter.sv
// Up-counter with synchronous clear, count enable and a terminal-count compare.
// Used for the PC-reset dwell and for the RUN cycle count.
module ctrl_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Compares the current value, so tc is seen during the cycle that holds tc_val.
  assign tc = (count == tc_val);

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer for the pipelined core: holds the core in PC reset, releases it,
// waits for halt or timeout, captures the result and offers it via valid/ack.
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  in_data,
  input  logic             result_ack,
  input  logic             core_halt,
  input  logic [OUT_W-1:0] core_out,
  output logic             core_pc_rst,
  output logic [IN_W-1:0]  core_in,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  output logic             timed_out,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_dwell
);

  // Result handshake: result_valid rises on capture and stays high with result,
  // timed_out and cycle_count frozen until a cycle with result_ack=1 or start=1;
  // that edge drops result_valid. There is no backpressure on the core side.

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       accept;
  logic       capture;
  logic       dwell_tc;
  logic       run_tc;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          accept   = 1'b1;
          state_nx = ST_RESET;
        end
      end
      ST_RESET: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (dwell_tc) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (core_halt || run_tc) begin
          capture  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start here doubles as the acknowledge of the pending result.
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_RESET;
        end else if (result_ack) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  ctrl_cycle_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (state == ST_RESET),
    .tc_val (CNT_W'(RST_CYCLES - 1)),
    .count  (dbg_dwell),
    .tc     (dwell_tc)
  );

  // Abort freezes the count; the capture cycle itself is still counted.
  ctrl_cycle_counter #(.CNT_W(CNT_W)) u_run (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     ((state == ST_RUN) && !abort),
    .tc_val (CNT_W'(TIMEOUT - 1)),
    .count  (cycle_count),
    .tc     (run_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      core_pc_rst  <= 1'b1;
      core_in      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      core_pc_rst  <= (state_nx != ST_RUN);
      busy         <= st_busy(state_nx);
      result_valid <= (state_nx == ST_DONE);
      if (accept) begin
        core_in   <= in_data;
        timed_out <= 1'b0;
      end
      if (capture) begin
        result    <= core_out;
        timed_out <= !core_halt;
      end
    end
  end

  assign dbg_state = state;

endmodule
